// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the write-back stage.
// Load-op encodings, bus widths and the WB pipeline register layout.
package wb_stage_pkg;

  localparam logic [2:0] LOAD_NONE = 3'd0;
  localparam logic [2:0] LOAD_LB   = 3'd1;
  localparam logic [2:0] LOAD_LBU  = 3'd2;
  localparam logic [2:0] LOAD_LH   = 3'd3;
  localparam logic [2:0] LOAD_LHU  = 3'd4;
  localparam logic [2:0] LOAD_LW   = 3'd5;

  localparam int WB_TO_ID_WD = 38;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] result;
    logic [2:0]  load_op;
    logic [1:0]  addr_lo;
  } wb_reg_t;

  function automatic logic is_load(input logic [2:0] op);
    return (op >= LOAD_LB) && (op <= LOAD_LW);
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data extraction: picks byte/halfword/word from SRAM data.
// In: load_op, addr_lo, rdata, result. Out: wdata.
module load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]  load_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] result,
  output logic [31:0] wdata
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    wdata  = result;
    unique case (1'b1)
      (load_op == LOAD_LB):  wdata = {{24{byte_v[7]}}, byte_v};
      (load_op == LOAD_LBU): wdata = {24'b0, byte_v};
      (load_op == LOAD_LH):  wdata = {{16{half_v[15]}}, half_v};
      (load_op == LOAD_LHU): wdata = {16'b0, half_v};
      (load_op == LOAD_LW):  wdata = rdata;
      default:               wdata = result;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: WB register, load alignment, regfile port, trace.
// In: stall/flush, mem_* bundle, SRAM rdata. Out: rf_*, wb_to_id, debug_*.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   mem_valid,
  input  logic [31:0]            mem_pc,
  input  logic                   mem_rf_we,
  input  logic [4:0]             mem_rf_waddr,
  input  logic [31:0]            mem_result,
  input  logic [2:0]             mem_load_op,
  input  logic [1:0]             mem_addr_lo,
  input  logic [31:0]            data_sram_rdata,
  output logic                   rf_we,
  output logic [4:0]             rf_waddr,
  output logic [31:0]            rf_wdata,
  output logic [WB_TO_ID_WD-1:0] wb_to_id,
  output logic [31:0]            debug_wb_pc,
  output logic [3:0]             debug_wb_rf_wen,
  output logic [4:0]             debug_wb_rf_wnum,
  output logic [31:0]            debug_wb_rf_wdata
);

  wb_reg_t     wb_q, wb_d;
  logic        rd_held_q, rd_held_d;
  logic [31:0] rd_hold_q, rd_hold_d;
  logic [31:0] ld_src;
  logic [31:0] wdata_final;
  logic        capture;

  // SRAM data is only live on the first WB cycle; keep it if we stall.
  assign capture = stall & wb_q.valid & is_load(wb_q.load_op) & ~rd_held_q;

  always_comb begin
    wb_d      = wb_q;
    rd_held_d = rd_held_q;
    rd_hold_d = rd_hold_q;
    if (flush) begin
      wb_d      = '0;
      rd_held_d = 1'b0;
    end else if (stall) begin
      if (capture) begin
        rd_held_d = 1'b1;
        rd_hold_d = data_sram_rdata;
      end
    end else begin
      wb_d.valid   = mem_valid;
      wb_d.pc      = mem_pc;
      wb_d.rf_we   = mem_rf_we;
      wb_d.waddr   = mem_rf_waddr;
      wb_d.result  = mem_result;
      wb_d.load_op = mem_load_op;
      wb_d.addr_lo = mem_addr_lo;
      rd_held_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_q      <= '0;
      rd_held_q <= 1'b0;
      rd_hold_q <= '0;
    end else begin
      wb_q      <= wb_d;
      rd_held_q <= rd_held_d;
      rd_hold_q <= rd_hold_d;
    end
  end

  assign ld_src = rd_held_q ? rd_hold_q : data_sram_rdata;

  load_align u_load_align (
    .load_op (wb_q.load_op),
    .addr_lo (wb_q.addr_lo),
    .rdata   (ld_src),
    .result  (wb_q.result),
    .wdata   (wdata_final)
  );

  // Forwarding stays asserted under stall; the regfile write does not.
  assign wb_to_id = {wb_q.valid & wb_q.rf_we, wb_q.waddr, wdata_final};

  assign rf_we    = wb_q.valid & wb_q.rf_we & ~stall;
  assign rf_waddr = wb_q.waddr;
  assign rf_wdata = wdata_final;

  assign debug_wb_pc       = wb_q.pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule
